// File: rtl/intersection_pkg.sv
// Shared light encodings, scheduler states and served-type tags for the
// intersection request scheduler.
package intersection_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    GRANT_SIDE,
    GRANT_WALK
  } state_e;

  typedef enum logic {
    SIDE = 1'b0,
    WALK = 1'b1
  } served_e;

  // 2'b11 is an illegal encoding and counts as red.
  function automatic logic light_lit(input logic [1:0] light);
    return (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous level inputs.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/intersection_request_scheduler.sv
// Latches side-road and pedestrian requests, enforces a minimum main-road green
// dwell, arbitrates fairly and hands requests to the phase engine until acknowledged.
module intersection_request_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned MIN_MAIN_GREEN = 20,
  parameter int unsigned ACK_TIMEOUT    = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic       walk_raw,
  input  logic [1:0] main_light,
  input  logic [1:0] side_light,
  input  logic       walk_light,
  output logic       sensor_req,
  output logic       walk_req,
  output logic       side_pending,
  output logic       walk_pending,
  output logic       busy,
  output logic       fault
);

  localparam logic [CNT_W-1:0] MinCnt  = CNT_W'(MIN_MAIN_GREEN);
  localparam logic [CNT_W-1:0] AckLast = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic sensor_s;
  logic walk_s;
  logic walk_s_q;
  logic walk_rise_q;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sensor_req_q;
  logic             walk_req_q;
  logic             side_pend_q;
  logic             walk_pend_q;
  logic             fault_q;
  served_e          last_q;

  logic main_green;
  logic side_ack;
  logic walk_ack;
  logic side_clr;
  logic walk_clr;

  sync_2ff u_sync_sensor (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor_raw),
    .q_o   (sensor_s)
  );

  sync_2ff u_sync_walk (
    .clk   (clk),
    .reset (reset),
    .d_i   (walk_raw),
    .q_o   (walk_s)
  );

  assign main_green = (main_light == LIGHT_GREEN);
  assign side_ack   = light_lit(side_light);
  assign walk_ack   = walk_light;
  assign side_clr   = (state_q == GRANT_SIDE) && side_ack;
  assign walk_clr   = (state_q == GRANT_WALK) && walk_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_s_q     <= 1'b0;
      walk_rise_q  <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      sensor_req_q <= 1'b0;
      walk_req_q   <= 1'b0;
      side_pend_q  <= 1'b0;
      walk_pend_q  <= 1'b0;
      fault_q      <= 1'b0;
      last_q       <= SIDE;
    end else begin
      walk_s_q    <= walk_s;
      walk_rise_q <= walk_s & ~walk_s_q;
      // A new request arriving on the acknowledge cycle must not be lost.
      side_pend_q <= sensor_s | (side_pend_q & ~side_clr);
      walk_pend_q <= walk_rise_q | (walk_pend_q & ~walk_clr);

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (main_green) state_q <= DWELL;
        end
        DWELL: begin
          if (!main_green) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if ((cnt_q == MinCnt) && (side_pend_q || walk_pend_q)) begin
            cnt_q <= '0;
            if (side_pend_q && (!walk_pend_q || (last_q == WALK))) begin
              state_q      <= GRANT_SIDE;
              sensor_req_q <= 1'b1;
            end else begin
              state_q    <= GRANT_WALK;
              walk_req_q <= 1'b1;
            end
          end else if (cnt_q < MinCnt) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        GRANT_SIDE: begin
          if (side_ack) begin
            sensor_req_q <= 1'b0;
            last_q       <= SIDE;
            state_q      <= IDLE;
            cnt_q        <= '0;
          end else if (cnt_q == AckLast) begin
            // Abandon the grant but keep the request pending for another try.
            sensor_req_q <= 1'b0;
            fault_q      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        GRANT_WALK: begin
          if (walk_ack) begin
            walk_req_q <= 1'b0;
            last_q     <= WALK;
            state_q    <= IDLE;
            cnt_q      <= '0;
          end else if (cnt_q == AckLast) begin
            walk_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sensor_req   = sensor_req_q;
  assign walk_req     = walk_req_q;
  assign side_pending = side_pend_q;
  assign walk_pending = walk_pend_q;
  assign busy         = (state_q == GRANT_SIDE) || (state_q == GRANT_WALK);
  assign fault        = fault_q;

endmodule
